// File: rtl/uP_io_pkg.sv
// uP_io_pkg: shared defaults and types for the pushbutton input stage.
package uP_io_pkg;
  localparam int NBTN_DEF = 4;
  localparam int DEBOUNCE_CYC_DEF = 4;
  typedef logic [NBTN_DEF-1:0] btn_vec_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: one-bit 2-FF synchronizer, counter debouncer and stable-rise pulse.
module btn_debounce
  import uP_io_pkg::*;
#(
  parameter int D = DEBOUNCE_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);
  localparam int CNT_W = $clog2(D);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(D - 1);
  logic s1_q, s2_q, stable_q, stable_d, done;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // any sample matching the stable level restarts the count
  always_comb begin
    done     = (s2_q != stable_q) && (cnt_q == CNT_MAX);
    cnt_d    = (s2_q == stable_q || done) ? '0 : cnt_q + CNT_W'(1);
    stable_d = done ? s2_q : stable_q;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      s1_q     <= raw_i;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end
  assign level_o = stable_q;
  assign rise_o  = done & s2_q;
endmodule

// File: rtl/pushbutton_input_stage.sv
// pushbutton_input_stage: debounced buttons plus sticky press flags feeding the uP IN nibble.
module pushbutton_input_stage
  import uP_io_pkg::*;
#(
  parameter int NBTN = NBTN_DEF,
  parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NBTN-1:0] btn_raw,
  input  logic            latch_mode,
  input  logic            rd_strobe,
  output logic [NBTN-1:0] in_data,
  output logic [NBTN-1:0] btn_level,
  output logic            event_pending
);
  logic [NBTN-1:0] level, rise, flag_q, flag_d;
  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    btn_debounce #(.D(DEBOUNCE_CYC)) u_db (
      .clk    (clk),
      .reset  (reset),
      .raw_i  (btn_raw[i]),
      .level_o(level[i]),
      .rise_o (rise[i])
    );
  end
  // a new press on the same edge as a read survives the clear
  assign flag_d = (flag_q & ~{NBTN{rd_strobe}}) | rise;
  always_ff @(posedge clk) begin
    if (!reset) flag_q <= '0;
    else flag_q <= flag_d;
  end
  assign btn_level     = level;
  assign in_data       = latch_mode ? flag_q : level;
  assign event_pending = |flag_q;
endmodule
